wptr_full_ctrl: RTL and testbench
=================================

// Module: wptr_full_ctrl
// PURPOSE
//  Write-side pointer/flag controller of the dual-clock FIFO, in the wclk domain.
//  Drives write address and full flag into the FIFO memory array (winc -> wclken).
//  Exports the Gray write pointer to the read-side synchronizer.
//  Consumes the 2-flop-synchronized Gray read pointer for full, level and almost-full status.
// PARAMETERS
//  ASIZE        4  address width; DEPTH = 1<<ASIZE entries; legal range ASIZE >= 2
//  AFULL_MARGIN 2  walmost_full asserts when level >= DEPTH-AFULL_MARGIN; legal range 1..DEPTH-1
// PORTS
//  wclk          in   1        write clock
//  wrst_n        in   1        async active-low reset
//  winc          in   1        write request; same value drives memory wclken
//  wq2_rptr      in   ASIZE+1  Gray read pointer, already synchronized into wclk
//  waddr         out  ASIZE    memory write address (= wbin[ASIZE-1:0])
//  wptr          out  ASIZE+1  registered Gray write pointer, to read-side sync
//  wfull         out  1        FIFO full; memory blocks the write while high
//  walmost_full  out  1        level >= DEPTH-AFULL_MARGIN
//  wlevel        out  ASIZE+1  write-side occupancy estimate, 0..DEPTH
//  woverflow     out  1        sticky: a winc was presented while wfull=1
// BEHAVIOUR
//  Reset: wrst_n low asynchronously clears wbin, wptr, wfull, walmost_full, wlevel, woverflow to 0.
//   Release is synchronized externally.
//   Reset mid-operation discards all content; the read side is reset in the same event.
//  Push: push = winc & ~wfull.
//   wbinnext = wbin + push, computed modulo 2^(ASIZE+1) so it wraps naturally.
//   wgraynext = (wbinnext>>1) ^ wbinnext.
//   Both wbin and wptr register every cycle.
//   waddr is combinational from wbin; data and address are valid in the same cycle as winc.
//  Full: wfull <= (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]}).
//   wfull is registered and asserts in the cycle after the DEPTH-th unread write.
//   Deassertion is delayed by the synchronizer latency (2-3 wclk). This pessimism is required.
//  Level: rbin_s = gray2bin(wq2_rptr).
//   wlevel <= wbinnext - rbin_s, ASIZE+1 bits, unsigned modulo. Never exceeds DEPTH.
//   The stale read pointer makes wlevel an over-estimate only, never an under-estimate.
//  Almost-full: walmost_full <= ((wbinnext - rbin_s) >= DEPTH-AFULL_MARGIN).
//   Same cycle alignment as wlevel. Always high whenever wfull is high.
//  Overflow: winc & wfull sets woverflow <= 1. Only reset clears it.
//   wbin/wptr do not advance on an overflow attempt.
//  Simultaneous winc and a read-pointer change: full is evaluated against the new wq2_rptr.
//   wfull may not assert if the read freed a slot in the same cycle.
//  wptr changes by at most one Gray bit per wclk (CDC requirement).
//   No combinational path from wq2_rptr to wptr.
// STRUCTURE
//  Shared package fifo_pkg:
//   localparam DEPTH = 1<<ASIZE, PTR_W = ASIZE+1
//   bin2gray/gray2bin functions, shared with the read-side rptr_empty block
//  One sub-module: gray2bin_conv (PTR_W-bit XOR-prefix, combinational)
//   Instantiated once for rbin_s.
//  Remainder: registers plus comparators in this module.
// TESTING (ASIZE=4, DEPTH=16, AFULL_MARGIN=2; wq2_rptr driven directly by the bench)
//  Reset: wrst_n=0 mid-burst -> all outputs 0 immediately, without waiting for a wclk edge.
//   After release: waddr=0, wptr=5'b00000.
//  Fill: wq2_rptr=0, 16 consecutive winc ->
//   walmost_full rises after the 14th write, wfull after the 16th.
//   wlevel=16; wptr=5'b11000 (Gray of 16).
//  Overflow: 17th winc with wfull=1 -> waddr stays 0, wptr unchanged, woverflow=1 and stays 1.
//  Drain: from full, set wq2_rptr=Gray(1)=5'b00001 -> next cycle wfull=0, wlevel=15, walmost_full=1.
//  Wrap: 40 writes interleaved with read-pointer advances keeping level<=8 ->
//   waddr wraps 15->0; wbin passes 31->0.
//   wfull never asserts; wlevel matches the reference model every cycle.
//  Gray check: over the full 32-value cycle, every wptr transition has Hamming distance exactly 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared dual-clock FIFO sizing plus Gray/binary helpers for wptr_full_ctrl and rptr_empty
package fifo_pkg;
  localparam int ASIZE = 4;
  localparam int DEPTH = 1 << ASIZE;
  localparam int PTR_W = ASIZE + 1;
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b = g;
    for (int i = PTR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter; ports g (Gray in), b (binary out), W bits wide
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b[i] = ^g[W-1:i];
  end
endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-side pointer/flag controller of the dual-clock FIFO (wclk domain)
// ports: wclk, wrst_n (async low), winc, wq2_rptr (synced Gray read ptr) in;
//        waddr, wptr (Gray), wfull, walmost_full, wlevel, woverflow (sticky) out
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ASIZE        = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             woverflow
);
  localparam logic [ASIZE:0] AF_LVL = (ASIZE+1)'((1 << ASIZE) - AFULL_MARGIN);
  logic [ASIZE:0] wbin, wbinnext, wgraynext, rbin_s, lvl_next;
  gray2bin_conv #(.W(ASIZE + 1)) u_g2b (.g(wq2_rptr), .b(rbin_s));
  assign waddr     = wbin[ASIZE-1:0];
  assign wbinnext  = wbin + (ASIZE+1)'(winc & ~wfull);
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;
  // stale read pointer only ever makes this an over-estimate
  assign lvl_next  = wbinnext - rbin_s;
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      // full when write ptr is exactly one lap ahead: top two Gray bits inverted
      wfull        <= wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
      walmost_full <= lvl_next >= AF_LVL;
      wlevel       <= lvl_next;
      woverflow    <= woverflow | (winc & wfull);
    end
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: directed plus randomized checks of wptr_full_ctrl against an occupancy-count model
module tb_wptr_full_ctrl;
  logic       wclk = 1'b0, wrst_n = 1'b0, winc = 1'b0;
  logic [4:0] wq2_rptr = '0, wptr, wlevel;
  logic [3:0] waddr;
  logic       wfull, walmost_full, woverflow;
  int         tests = 0, fails = 0, wcount = 0, rcount = 0;
  bit         ovf = 1'b0, exp_full = 1'b0;
  logic [4:0] prev;
  always #5 wclk = ~wclk;
  wptr_full_ctrl #(.ASIZE(4), .AFULL_MARGIN(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .woverflow(woverflow)
  );
  function automatic logic [4:0] gray(input int n);
    int b = n % 32;
    return 5'(b ^ (b >> 1));
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic check_zero();
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wptr", 32'(wptr), 0);
    check("rst_wfull", 32'(wfull), 0);
    check("rst_afull", 32'(walmost_full), 0);
    check("rst_wlevel", 32'(wlevel), 0);
    check("rst_ovf", 32'(woverflow), 0);
  endtask
  task automatic step(input bit w, input int r);
    int  lvl;
    bit  push;
    winc     = w;
    rcount   = r;
    wq2_rptr = gray(r);
    prev     = wptr;
    @(posedge wclk);
    push = w && !exp_full;
    if (w && exp_full) ovf = 1'b1;
    wcount += int'(push);
    lvl      = wcount - r;
    exp_full = (lvl == 16);
    #1;
    check("waddr", 32'(waddr), 32'(wcount % 16));
    check("wptr", 32'(wptr), 32'(gray(wcount)));
    check("wlevel", 32'(wlevel), 32'(lvl));
    check("wfull", 32'(wfull), 32'(exp_full));
    check("walmost_full", 32'(walmost_full), 32'(lvl >= 14));
    check("woverflow", 32'(woverflow), 32'(ovf));
    check("gray_hamming", 32'($countones(wptr ^ prev)), 32'(push));
  endtask
  task automatic model_reset();
    wcount = 0; rcount = 0; ovf = 1'b0; exp_full = 1'b0;
  endtask
  initial begin
    int n, r;
    bit w;
    repeat (2) @(posedge wclk);
    #1 check_zero();
    @(negedge wclk) wrst_n = 1'b1;
    #1;
    check("rel_waddr", 32'(waddr), 0);
    check("rel_wptr", 32'(wptr), 0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 0);
      if (i == 13) check("afull_13", 32'(walmost_full), 0);
      if (i == 14) check("afull_14", 32'(walmost_full), 1);
      if (i == 15) check("full_15", 32'(wfull), 0);
    end
    check("fill_wptr", 32'(wptr), 32'h18);
    check("fill_wlevel", 32'(wlevel), 16);
    check("fill_wfull", 32'(wfull), 1);
    step(1'b1, 0);
    check("ovf_waddr", 32'(waddr), 0);
    check("ovf_wptr", 32'(wptr), 32'h18);
    check("ovf_set", 32'(woverflow), 1);
    step(1'b1, 0);
    step(1'b0, 0);
    check("ovf_sticky", 32'(woverflow), 1);
    step(1'b0, 1);
    check("drain_wfull", 32'(wfull), 0);
    check("drain_wlevel", 32'(wlevel), 15);
    check("drain_afull", 32'(walmost_full), 1);
    while (wcount - rcount > 8) step(1'b0, rcount + 1);
    n = 0;
    for (int k = 0; k < 1000 && n < 40; k++) begin
      r = rcount;
      if (r < wcount && ($urandom_range(0, 1) == 1 || wcount - r >= 8)) r++;
      w = ($urandom_range(0, 3) != 0) && (wcount + 1 - r <= 8);
      step(w, r);
      if (w) n++;
    end
    check("wrap_writes", 32'(n), 40);
    check("wrap_passed", 32'(wcount > 32), 1);
    for (int i = 0; i < 3; i++) step(1'b1, rcount);
    #2 wrst_n = 1'b0;
    #1 check_zero();
    model_reset();
    @(negedge wclk) wrst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
